// File: rtl/mips_trace_pkg.sv
// Shared types and layout constants for the MIPS pipeline event tracer.
// Optional feature macro: MIPS_TRACE_TIMESTAMP_EN (adds a timestamp field to
// the top of every trace entry).
package mips_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_STOPPED = 2'd3
  } trace_state_t;

  // Bit positions inside the 3-bit event mask of an entry.
  localparam int MASK_WB = 0;
  localparam int MASK_MR = 1;
  localparam int MASK_MW = 2;
  localparam int MASK_W  = 3;

  // Default field widths of the tracer.
  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_W  = 5;
  localparam int DEF_TS_W   = 16;

`ifdef MIPS_TRACE_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif

  // Entry layout, MSB first: {[ts], pc, mask, wb_reg, wb_data, mem_addr, mem_data}.
  function automatic int entry_w(input int data_w, input int reg_w, input int ts_w);
    return (TS_EN ? ts_w : 0) + 4 * data_w + MASK_W + reg_w;
  endfunction

  // Field offsets for the default widths.
  localparam int OFF_MEM_DATA = 0;
  localparam int OFF_MEM_ADDR = OFF_MEM_DATA + DEF_DATA_W;
  localparam int OFF_WB_DATA  = OFF_MEM_ADDR + DEF_DATA_W;
  localparam int OFF_WB_REG   = OFF_WB_DATA + DEF_DATA_W;
  localparam int OFF_MASK     = OFF_WB_REG + DEF_REG_W;
  localparam int OFF_PC       = OFF_MASK + MASK_W;
  localparam int OFF_TS       = OFF_PC + DEF_DATA_W;

endpackage

// File: rtl/mips_trace_buffer_if.sv
// Host read port of the trace buffer: valid/ready handshake carrying one entry.
interface mips_trace_buffer_if
  import mips_trace_pkg::*;
#(
  parameter int ENTRY_W = entry_w(DEF_DATA_W, DEF_REG_W, DEF_TS_W)
);
  logic               rd_valid;
  logic               rd_ready;
  logic [ENTRY_W-1:0] rd_data;

  // The tracer drives entries out; the host drains them.
  modport master (output rd_valid, output rd_data, input rd_ready);
  modport slave  (input rd_valid, input rd_data, output rd_ready);
endinterface

// File: rtl/mips_trace_fifo.sv
// Circular trace store with first-word-fall-through read. When full and no
// pop is taking a slot, a push is either dropped (WRAP=0) or overwrites the
// oldest entry (WRAP=1); both cases raise 'lost' for the overflow counter.
module mips_trace_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int WRAP  = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   pop_req,
  output logic                   rd_valid,
  output logic [WIDTH-1:0]       rd_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   lost
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic             full;
  logic             empty;
  logic             pop;
  logic             wr_en;
  logic             adv_r;

  assign empty = (level == '0);
  assign full  = (level == LVL_W'(DEPTH));
  assign pop   = pop_req && !empty;
  assign lost  = push && full && !pop;
  // In wrap mode a full push lands on the oldest slot, so the read side moves too.
  assign wr_en = push && (!lost || WRAP != 0);
  assign adv_r = pop || (lost && WRAP != 0);

  // Storage write; readers only ever see slots covered by 'level'.
  // NOTE: the memory array has no reset -- occupancy is tracked by the pointers, so clearing it would only cost logic.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= wr_data;
  end

  // Pointer and occupancy bookkeeping; flush empties the buffer in one cycle.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (adv_r) rptr <= rptr + 1'b1;
      if (wr_en && !adv_r)      level <= level + 1'b1;
      else if (adv_r && !wr_en) level <= level - 1'b1;
    end
  end

  // Head of the buffer falls through; an empty buffer presents zero. In wrap
  // mode an overwrite while stalled advances the head to the new oldest entry.
  assign rd_valid = !empty;
  assign rd_data  = empty ? '0 : mem[rptr];

endmodule

// File: rtl/mips_trace_buffer.sv
// On-chip event tracer for the MIPS pipeline: qualifies WB/MEM events, runs
// the arm/trigger/capture FSM, stages one entry per cycle into the circular
// buffer and counts lost entries.
// Optional feature macro: MIPS_TRACE_TIMESTAMP_EN (free-running cycle stamp
// placed in the MSBs of each entry).
module mips_trace_buffer
  import mips_trace_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_W  = DEF_REG_W,
  parameter int WRAP   = 0,
  parameter int TS_W   = DEF_TS_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_W-1:0]      pc,
  input  logic                   wb_en,
  input  logic [REG_W-1:0]       wb_reg,
  input  logic [DATA_W-1:0]      wb_data,
  input  logic                   mr_en,
  input  logic                   mw_en,
  input  logic [DATA_W-1:0]      mem_addr,
  input  logic [DATA_W-1:0]      mem_data,
  input  logic                   arm,
  input  logic                   stop,
  input  logic                   clr,
  input  logic                   trig_en,
  input  logic [DATA_W-1:0]      trig_pc,
  input  logic [2**REG_W-1:0]    reg_mask,
  mips_trace_buffer_if.master    rd,
  output logic [$clog2(DEPTH):0] level,
  output logic [15:0]            overflow,
  output logic [1:0]             state
);

  localparam int ENTRY_W = entry_w(DATA_W, REG_W, TS_W);

  trace_state_t       state_q;
  trace_state_t       state_d;
  logic               capture_now;
  logic               trig_hit;
  logic               wbq;
  logic [MASK_W-1:0]  ev_mask;
  logic [ENTRY_W-1:0] entry_d;
  logic               stage_valid;
  logic [ENTRY_W-1:0] stage_entry;
  logic               lost;

  // Event qualification: writes to $0 and masked registers are not traced.
  assign wbq               = wb_en && reg_mask[wb_reg] && (wb_reg != '0);
  assign ev_mask[MASK_WB]  = wbq;
  assign ev_mask[MASK_MR]  = mr_en;
  assign ev_mask[MASK_MW]  = mw_en;
  assign trig_hit          = !trig_en || (pc == trig_pc);

`ifdef MIPS_TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;

  // Free-running cycle stamp, restarted by reset and clr.
  always_ff @(posedge clk) begin
    if (rst || clr) ts_q <= '0;
    else            ts_q <= ts_q + 1'b1;
  end

  assign entry_d = {ts_q, pc, ev_mask, wb_reg, wb_data, mem_addr, mem_data};
`else
  assign entry_d = {pc, ev_mask, wb_reg, wb_data, mem_addr, mem_data};
`endif

  // Control FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state and capture decision; clr outranks stop, stop outranks arm.
  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    capture_now = 1'b0;
    if (clr) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_STOPPED: if (arm) state_d = ST_ARMED;
        ST_ARMED: begin
          if (trig_hit) begin
            state_d     = ST_CAPTURE;
            capture_now = 1'b1;
          end
        end
        ST_CAPTURE: begin
          if (stop) begin
            state_d = ST_STOPPED;
          end else begin
            capture_now = 1'b1;
            // Stop-on-full: the first lost entry ends the capture window.
            if (WRAP == 0 && lost) state_d = ST_STOPPED;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Capture stage: one-cycle register between the pipeline taps and the buffer.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      stage_valid <= 1'b0;
      stage_entry <= '0;
    end else begin
      stage_valid <= capture_now && (ev_mask != '0);
      if (capture_now) stage_entry <= entry_d;
    end
  end

  // Saturating count of dropped or overwritten entries.
  always_ff @(posedge clk) begin
    if (rst || clr)                         overflow <= '0;
    else if (lost && overflow != 16'hFFFF)  overflow <= overflow + 16'd1;
  end

  mips_trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W),
    .WRAP  (WRAP)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (clr),
    .push     (stage_valid),
    .wr_data  (stage_entry),
    .pop_req  (rd.rd_ready),
    .rd_valid (rd.rd_valid),
    .rd_data  (rd.rd_data),
    .level    (level),
    .lost     (lost)
  );

  assign state = state_q;

endmodule

// File: tb/tb_mips_trace_buffer.sv
// Bench for mips_trace_buffer: two DEPTH=4 instances (stop-on-full and wrap)
// share stimulus; a queue-based reference model predicts every output.
module tb_mips_trace_buffer;
  import mips_trace_pkg::*;

  localparam int EW    = entry_w(DEF_DATA_W, DEF_REG_W, DEF_TS_W);
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc, wb_data, mem_addr, mem_data, trig_pc, reg_mask;
  logic [4:0]  wb_reg;
  logic        wb_en, mr_en, mw_en, arm, stop, clr, trig_en;

  logic          o_valid [2];
  logic [EW-1:0] o_data  [2];
  logic [2:0]    o_level [2];
  logic [15:0]   o_ovf   [2];
  logic [1:0]    o_state [2];

  mips_trace_buffer_if #(.ENTRY_W(EW)) rif0 ();
  mips_trace_buffer_if #(.ENTRY_W(EW)) rif1 ();

  mips_trace_buffer #(.DEPTH(DEPTH), .WRAP(0)) dut0 (
    .clk(clk), .rst(rst), .pc(pc), .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
    .mr_en(mr_en), .mw_en(mw_en), .mem_addr(mem_addr), .mem_data(mem_data),
    .arm(arm), .stop(stop), .clr(clr), .trig_en(trig_en), .trig_pc(trig_pc),
    .reg_mask(reg_mask), .rd(rif0), .level(o_level[0]), .overflow(o_ovf[0]),
    .state(o_state[0])
  );

  mips_trace_buffer #(.DEPTH(DEPTH), .WRAP(1)) dut1 (
    .clk(clk), .rst(rst), .pc(pc), .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
    .mr_en(mr_en), .mw_en(mw_en), .mem_addr(mem_addr), .mem_data(mem_data),
    .arm(arm), .stop(stop), .clr(clr), .trig_en(trig_en), .trig_pc(trig_pc),
    .reg_mask(reg_mask), .rd(rif1), .level(o_level[1]), .overflow(o_ovf[1]),
    .state(o_state[1])
  );

  assign o_valid[0] = rif0.rd_valid;
  assign o_valid[1] = rif1.rd_valid;
  assign o_data[0]  = rif0.rd_data;
  assign o_data[1]  = rif1.rd_data;

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [EW-1:0] got, input logic [EW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Reference model: per instance a queue of entries, the entry captured on
  // the previous edge, the overflow count and the state (0..3).
  logic [EW-1:0] mq [2][$];
  logic [EW-1:0] m_pe [2];
  bit            m_pv [2];
  int            m_ovf [2];
  int            m_st [2];
  int            m_ts;
  logic          rdy [2];

  function automatic logic [EW-1:0] build(input logic [2:0] mk, input int ts);
    logic [EW-1:0] e;
    e = '0;
    e[OFF_MEM_DATA +: 32] = mem_data;
    e[OFF_MEM_ADDR +: 32] = mem_addr;
    e[OFF_WB_DATA  +: 32] = wb_data;
    e[OFF_WB_REG   +: 5]  = wb_reg;
    e[OFF_MASK     +: 3]  = mk;
    e[OFF_PC       +: 32] = pc;
`ifdef MIPS_TRACE_TIMESTAMP_EN
    e[OFF_TS +: DEF_TS_W] = ts[DEF_TS_W-1:0];
`endif
    return e;
  endfunction

  function automatic logic [31:0] field(input logic [EW-1:0] e, input int off, input int w);
    logic [EW-1:0] t;
    t = e >> off;
    return t[31:0] & ((w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1));
  endfunction

  // Advance the model by one rising edge using the inputs held across it.
  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      bit         pop;
      bit         lost;
      bit         cap;
      logic [2:0] mk;
      if (rst || clr) begin
        mq[d].delete();
        m_pv[d]  = 1'b0;
        m_ovf[d] = 0;
        m_st[d]  = 0;
      end else begin
        pop  = rdy[d] && (mq[d].size() > 0);
        lost = 1'b0;
        cap  = 1'b0;
        if (pop) void'(mq[d].pop_front());
        if (m_pv[d]) begin
          if (mq[d].size() < DEPTH) begin
            mq[d].push_back(m_pe[d]);
          end else begin
            lost = 1'b1;
            if (m_ovf[d] < 65535) m_ovf[d]++;
            if (d == 1) begin
              void'(mq[d].pop_front());
              mq[d].push_back(m_pe[d]);
            end
          end
        end
        case (m_st[d])
          0, 3: if (arm) m_st[d] = 1;
          1: if (!trig_en || pc == trig_pc) begin cap = 1'b1; m_st[d] = 2; end
          default: begin
            if (stop) m_st[d] = 3;
            else begin
              cap = 1'b1;
              if (d == 0 && lost) m_st[d] = 3;
            end
          end
        endcase
        mk = {mw_en, mr_en, wb_en && reg_mask[wb_reg] && (wb_reg != 5'd0)};
        m_pv[d] = cap && (mk != 3'b000);
        if (m_pv[d]) m_pe[d] = build(mk, m_ts);
      end
    end
    m_ts = (rst || clr) ? 0 : m_ts + 1;
  endtask

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      logic [EW-1:0] exp_data;
      exp_data = (mq[d].size() > 0) ? mq[d][0] : '0;
      check($sformatf("dut%0d rd_valid", d), EW'(o_valid[d]), EW'(mq[d].size() > 0));
      check($sformatf("dut%0d rd_data", d), o_data[d], exp_data);
      check($sformatf("dut%0d level", d), EW'(o_level[d]), EW'(mq[d].size()));
      check($sformatf("dut%0d overflow", d), EW'(o_ovf[d]), EW'(m_ovf[d]));
      check($sformatf("dut%0d state", d), EW'(o_state[d]), EW'(m_st[d]));
    end
  endtask

  task automatic cyc();
    rif0.rd_ready = rdy[0];
    rif1.rd_ready = rdy[1];
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic quiet();
    wb_en = 1'b0; mr_en = 1'b0; mw_en = 1'b0;
    arm = 1'b0; stop = 1'b0; clr = 1'b0;
  endtask

  task automatic wb(input logic [4:0] r, input logic [31:0] v);
    quiet();
    wb_en = 1'b1; wb_reg = r; wb_data = v;
  endtask

  task automatic pulse_clr();
    quiet(); clr = 1'b1; cyc(); clr = 1'b0;
  endtask

  task automatic pulse_arm();
    quiet(); arm = 1'b1; cyc(); arm = 1'b0;
  endtask

  initial begin
    rst = 1'b1; quiet();
    pc = 32'h100; wb_reg = '0; wb_data = '0; mem_addr = '0; mem_data = '0;
    trig_en = 1'b0; trig_pc = '0; reg_mask = '1;
    rdy[0] = 1'b0; rdy[1] = 1'b0;
    m_ts = 0;
    for (int d = 0; d < 2; d++) begin m_pv[d] = 1'b0; m_ovf[d] = 0; m_st[d] = 0; m_pe[d] = '0; end
    cyc(); cyc();
    check("reset rd_valid", EW'(o_valid[0]), EW'(0));
    check("reset rd_data", o_data[0], '0);
    check("reset state", EW'(o_state[1]), EW'(ST_IDLE));
    rst = 1'b0;

    // Immediate trigger, single write-back of $t0.
    pulse_arm();
    wb(5'd8, 32'd5); cyc();
    quiet(); cyc();
    check("t1 rd_valid", EW'(o_valid[0]), EW'(1));
    check("t1 mask", EW'(field(o_data[0], OFF_MASK, 3)), EW'(3'b001));
    check("t1 wb_reg", EW'(field(o_data[0], OFF_WB_REG, 5)), EW'(8));
    check("t1 wb_data", EW'(field(o_data[0], OFF_WB_DATA, 32)), EW'(5));

    // PC trigger at 0x20: earlier events are ignored.
    pulse_clr();
    trig_en = 1'b1; trig_pc = 32'h20;
    pulse_arm();
    for (int i = 0; i < 4; i++) begin
      wb(5'd9, 32'(i)); mr_en = 1'b1; pc = 32'h10 + 32'(4 * i); cyc();
    end
    wb(5'd9, 32'h20); pc = 32'h20; cyc();
    quiet(); pc = 32'h24; cyc(); cyc();
    check("t2 level", EW'(o_level[0]), EW'(1));
    check("t2 pc", EW'(field(o_data[0], OFF_PC, 32)), EW'(32'h20));
    check("t2 state", EW'(o_state[0]), EW'(ST_CAPTURE));
    stop = 1'b1; cyc(); stop = 1'b0;
    trig_en = 1'b0;

    // Register filter: only $s0 traced, $0 never.
    pulse_clr();
    reg_mask = 32'h0001_0001;
    pulse_arm();
    wb(5'd9, 32'd1); cyc();
    wb(5'd16, 32'd7); cyc();
    wb(5'd0, 32'd3); cyc();
    quiet(); cyc(); cyc();
    check("t3 level", EW'(o_level[0]), EW'(1));
    check("t3 wb_reg", EW'(field(o_data[0], OFF_WB_REG, 5)), EW'(16));
    check("t3 wb_data", EW'(field(o_data[0], OFF_WB_DATA, 32)), EW'(7));
    reg_mask = '1;

    // Six events into a 4-deep buffer with no reads.
    pulse_clr();
    pulse_arm();
    for (int i = 1; i <= 6; i++) begin wb(5'd8, 32'(i)); cyc(); end
    quiet(); cyc(); cyc();
    check("t4 level", EW'(o_level[0]), EW'(4));
    check("t4 overflow", EW'(o_ovf[0]), EW'(2));
    check("t4 state", EW'(o_state[0]), EW'(ST_STOPPED));
    check("t5 level", EW'(o_level[1]), EW'(4));
    check("t5 overflow", EW'(o_ovf[1]), EW'(2));
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t4 order %0d", i), EW'(field(o_data[0], OFF_WB_DATA, 32)), EW'(1 + i));
      check($sformatf("t5 order %0d", i), EW'(field(o_data[1], OFF_WB_DATA, 32)), EW'(3 + i));
      rdy[0] = 1'b1; rdy[1] = 1'b1; cyc();
      rdy[0] = 1'b0; rdy[1] = 1'b0;
    end
    check("t5 empty", EW'(o_valid[1]), EW'(0));

    // Simultaneous WB + store, then full with push and pop, then clr mid-capture.
    pulse_clr();
    pulse_arm();
    wb(5'd8, 32'hAA); mw_en = 1'b1; mem_addr = 32'h40; mem_data = 32'h55; cyc();
    quiet(); cyc();
    check("t6 mask", EW'(field(o_data[0], OFF_MASK, 3)), EW'(3'b101));
    pulse_clr();
    pulse_arm();
    for (int i = 1; i <= 5; i++) begin wb(5'd10, 32'(i)); cyc(); end
    wb(5'd10, 32'd6); rdy[0] = 1'b1; rdy[1] = 1'b1; cyc();
    rdy[0] = 1'b0; rdy[1] = 1'b0;
    check("t6 full level", EW'(o_level[0]), EW'(4));
    check("t6 no overflow", EW'(o_ovf[1]), EW'(0));
    wb(5'd10, 32'd7); clr = 1'b1; cyc(); quiet();
    check("t6 clr level", EW'(o_level[1]), EW'(0));
    check("t6 clr state", EW'(o_state[0]), EW'(ST_IDLE));

    // Randomized traffic.
    for (int n = 0; n < 2000; n++) begin
      rst      = ($urandom_range(0, 299) == 0);
      clr      = ($urandom_range(0, 79) == 0);
      arm      = ($urandom_range(0, 11) == 0);
      stop     = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 49) == 0) trig_en = 1'($urandom_range(0, 1));
      trig_pc  = 32'h20 + 32'(4 * $urandom_range(0, 3));
      pc       = 32'h20 + 32'(4 * $urandom_range(0, 7));
      wb_en    = 1'($urandom_range(0, 1));
      wb_reg   = 5'($urandom_range(0, 31));
      wb_data  = $urandom;
      mr_en    = ($urandom_range(0, 3) == 0);
      mw_en    = ($urandom_range(0, 3) == 0);
      mem_addr = $urandom;
      mem_data = $urandom;
      if ($urandom_range(0, 19) == 0) reg_mask = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : $urandom;
      rdy[0]   = ($urandom_range(0, 2) == 0);
      rdy[1]   = ($urandom_range(0, 2) == 0);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
